// File: rtl/iter_muldiv_alu.sv
// Multi-cycle RV32M multiply/divide unit with a radix-2 shift-add / restoring-divide datapath.
// Issue and result sides use valid/ready handshakes; kill flushes any in-flight op.
module iter_muldiv_alu #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FAST_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinInt  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] b_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q;   // partial product high half or partial remainder
  logic [WIDTH-1:0] lo_q;   // multiplier / dividend, shifting out as the result shifts in
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;

  logic             accept;
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    is_div   = in_op[2];
    a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
    b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    a_neg    = a_signed & in_a[WIDTH-1];
    b_neg    = b_signed & in_b[WIDTH-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    special     = 1'b0;
    special_res = '0;
    if (is_div) begin
      if (in_b == '0) begin
        special     = 1'b1;
        special_res = in_op[1] ? in_a : AllOnes;
      end else if (!in_op[0] && (in_a == MinInt) && (in_b == AllOnes)) begin
        special     = 1'b1;
        special_res = in_op[1] ? '0 : MinInt;
      end
    end else if ((FAST_ZERO != 0) && ((in_a == '0) || (in_b == '0))) begin
      special = 1'b1;
    end
  end

  assign accept = in_valid & (state_q == StIdle) & ~kill;

  logic [WIDTH:0]     mul_sum, shifted;
  logic [WIDTH-1:0]   addend, sub, hi_n, lo_n, quo_fix, rem_fix, res_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               fits;

  always_comb begin
    addend  = lo_q[0] ? b_q : '0;
    mul_sum = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, b_q};
    sub     = shifted[WIDTH-1:0] - b_q;
    if (op_q[2]) begin
      hi_n = fits ? sub : shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], fits};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    // Full product as it stands after this step; only meaningful on the final step.
    prod     = {mul_sum, lo_q[WIDTH-1:1]};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_n : lo_n;
    rem_fix  = neg_q ? -hi_n : hi_n;
    if (op_q[2]) begin
      res_n = op_q[1] ? rem_fix : quo_fix;
    end else begin
      res_n = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= '0;
      neg_q <= 1'b0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q  <= in_op;
      neg_q <= (is_div & in_op[1]) ? a_neg : (a_neg ^ b_neg);
      hi_q  <= '0;
      cnt_q <= CntW'(WIDTH - 1);
      if (is_div) begin
        lo_q <= a_mag;
        b_q  <= b_mag;
      end else begin
        lo_q <= b_mag;
        b_q  <= a_mag;
      end
      if (special) begin
        res_q <= special_res;
      end
    end else if (state_q == StCalc) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == '0) begin
        res_q <= res_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = special ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (kill) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (kill || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = res_q;
  end

endmodule
